ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
- Parametrised successor to the team's 64x4096 simple dual-port RAM: one write port, one read port, one clock.
- Adds per-byte write enables and a selectable read-during-write mode.
- Adds an optional output pipeline register, a read-valid strobe and a collision flag.
- Adds a post-reset hardware clear sweep. Used as the generic buffer memory behind packet and DMA datapaths.

Parameters:
RAM_WIDTH, 64, data word width in bits; must be a multiple of BYTE_WIDTH
RAM_DEPTH, 4096, number of words; must satisfy RAM_DEPTH <= 2**ADDR_SIZE
ADDR_SIZE, 12, address width in bits
BYTE_WIDTH, 8, bits per write-enable lane; NUM_LANES = RAM_WIDTH/BYTE_WIDTH
RDW_MODE, 0, read-during-write to the same address: 0 = old data, 1 = new data (write-through)
OUT_REG, 0, 0 = read latency 1, 1 = extra output register, read latency 2
INIT_VALUE, 0, RAM_WIDTH-bit value written to every word by the clear sweep

Ports:
clock  input  1  single clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  RAM_WIDTH  write data
byte_en  input  NUM_LANES  lane i enables data_in[i*BYTE_WIDTH +: BYTE_WIDTH]
wrt_address  input  ADDR_SIZE  write address
write  input  1  write request
rd_address  input  ADDR_SIZE  read address
read  input  1  read request
data_out  output  RAM_WIDTH  read data
rd_valid  output  1  one-cycle strobe; data_out updated this cycle
collision  output  1  one-cycle strobe aligned with rd_valid; that read hit a same-cycle write
init_busy  output  1  high while the clear sweep runs; requests ignored

Behaviour:
- Reset (reset_n low, asynchronous):
  - data_out=0, rd_valid=0, collision=0, init_busy=1.
  - All pipeline registers cleared; sweep pointer=0; FSM enters INIT.
  - Memory array contents are not reset directly.
- FSM INIT:
  - Each clock writes INIT_VALUE to ram[ptr], then ptr++.
  - After writing ptr=RAM_DEPTH-1, the next edge enters RUN and init_busy falls.
  - The sweep takes exactly RAM_DEPTH cycles after reset_n rises.
  - read/write ignored; rd_valid and collision stay 0.
  - reset_n low mid-sweep restarts the sweep from ptr=0.
- FSM RUN: stays in RUN until reset.
- Write:
  - On an edge with write=1, each lane with byte_en[i]=1 is updated; other lanes keep their contents.
  - write=1 with byte_en=0 is a no-op.
- Read:
  - A read accepted at edge N drives data_out and rd_valid=1 at edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1).
  - Back-to-back reads at full rate, one result per cycle.
  - data_out holds its last value when no result is delivered; rd_valid=0 on those cycles.
- Out-of-range addresses (address >= RAM_DEPTH):
  - Such a write is dropped.
  - Such a read returns 0 with rd_valid=1.
- Collision condition: read=1, write=1, rd_address==wrt_address, byte_en!=0, in RUN.
  - collision=1 on the same cycle as that read's rd_valid.
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word; enabled lanes from data_in, others old.
- Writes to different addresses never disturb reads.
- OUT_REG=1: rd_valid and collision are delayed together with data; both stages are cleared by reset.
- Elaboration must fail if RAM_WIDTH % BYTE_WIDTH != 0 or RAM_DEPTH > 2**ADDR_SIZE.

Test Plan:
- Sweep: release reset_n with defaults -> init_busy high for exactly 4096 cycles. Reads of addresses 0, 2047 and 4095 afterwards return 0 with rd_valid one cycle after request.
- Byte enables: write 64'h1111_2222_3333_4444 to addr 5 with byte_en=8'hFF, then 64'hAAAA_BBBB_CCCC_DDDD with byte_en=8'h0F -> read addr 5 returns 64'h1111_2222_CCCC_DDDD.
- RDW old: addr 9 holds 64'h55; same-cycle write 64'h77 (byte_en=8'hFF) and read of addr 9, RDW_MODE=0 -> data_out=64'h55, collision=1; a later read returns 64'h77.
- RDW new: repeat the previous case with RDW_MODE=1, byte_en=8'h01 and write data 64'hFF -> data_out=64'hFF, collision=1.
- Pipeline: OUT_REG=1, reads of addrs 1, 2, 3 on consecutive cycles -> rd_valid high on cycles +2, +3, +4 with matching data; data_out holds afterwards.
- Reset mid-operation: assert reset_n low at sweep ptr=100 and with a read in flight -> outputs go to 0 immediately, no rd_valid follows, and the sweep restarts for a full 4096 cycles.

Source files
------------

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear sweep.
module ram_dp_be #(
    parameter int                   RAM_WIDTH  = 64,
    parameter int                   RAM_DEPTH  = 4096,
    parameter int                   ADDR_SIZE  = 12,
    parameter int                   BYTE_WIDTH = 8,
    parameter int                   RDW_MODE   = 0,
    parameter int                   OUT_REG    = 0,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [RAM_WIDTH-1:0]              data_in,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]   byte_en,
    input  logic [ADDR_SIZE-1:0]              wrt_address,
    input  logic                              write,
    input  logic [ADDR_SIZE-1:0]              rd_address,
    input  logic                              read,
    output logic [RAM_WIDTH-1:0]              data_out,
    output logic                              rd_valid,
    output logic                              collision,
    output logic                              init_busy
);
    localparam int NUM_LANES = RAM_WIDTH / BYTE_WIDTH;

    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_dp_be: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (longint'(RAM_DEPTH) > (longint'(1) << ADDR_SIZE)) begin : g_bad_depth
        $error("ram_dp_be: RAM_DEPTH does not fit in ADDR_SIZE address bits");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state;
    logic [ADDR_SIZE-1:0]   ptr;
    logic                   init_busy_r;
    logic [RAM_WIDTH-1:0]   ram [RAM_DEPTH];

    logic                   run;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   wr_en;
    logic                   rd_en;
    logic                   collide_c;
    logic [RAM_WIDTH-1:0]   wr_mask;
    logic [RAM_WIDTH-1:0]   rd_word;

    assign run         = (state == ST_RUN);
    assign wr_in_range = (int'(wrt_address) < RAM_DEPTH);
    assign rd_in_range = (int'(rd_address) < RAM_DEPTH);
    assign wr_en       = run && write && wr_in_range;
    assign rd_en       = run && read;
    assign collide_c   = run && read && write && (rd_address == wrt_address) && (|byte_en);
    assign init_busy   = init_busy_r;

    // Clear sweep: one word per clock, then RUN until the next reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            ptr         <= '0;
            init_busy_r <= 1'b1;
        end else if (state == ST_INIT) begin
            if (ptr == ADDR_SIZE'(RAM_DEPTH - 1)) begin
                state       <= ST_RUN;
                init_busy_r <= 1'b0;
            end else begin
                ptr <= ptr + ADDR_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!run) begin
            ram[ptr] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byte_en[i]) begin
                    ram[wrt_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Same-address write can be folded into the read word for write-through mode
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{byte_en[i]}};
        end
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = ram[rd_address];
            if ((RDW_MODE != 0) && collide_c) begin
                rd_word = (rd_word & ~wr_mask) | (data_in & wr_mask);
            end
        end
    end

    // Stage p0: read result register
    logic [RAM_WIDTH-1:0] data_p0;
    logic                 vld_p0;
    logic                 col_p0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
            col_p0  <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
            col_p0 <= collide_c;
            if (rd_en) begin
                data_p0 <= rd_word;
            end
        end
    end

    // Stage p1: optional output register, strobes travel with the data
    if (OUT_REG != 0) begin : g_out_reg
        logic [RAM_WIDTH-1:0] data_p1;
        logic                 vld_p1;
        logic                 col_p1;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
                col_p1  <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                col_p1 <= col_p0;
                if (vld_p0) begin
                    data_p1 <= data_p0;
                end
            end
        end

        assign data_out  = data_p1;
        assign rd_valid  = vld_p1;
        assign collision = col_p1;
    end else begin : g_no_out_reg
        assign data_out  = data_p0;
        assign rd_valid  = vld_p0;
        assign collision = col_p0;
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: four instances (old/new read-during-write,
// output register, reduced depth) driven by one shared stimulus stream.
module tb_ram_dp_be;

    typedef struct packed {
        logic [3:0][63:0] d;
        logic             c;
        int unsigned      cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] data_in = '0;
    logic [7:0]  byte_en = '0;
    logic [11:0] wrt_address = '0;
    logic        write = 1'b0;
    logic [11:0] rd_address = '0;
    logic        read = 1'b0;

    logic [63:0] dout [4];
    logic        vld  [4];
    logic        col  [4];
    logic        busy [4];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    exp_t        q1 [$];
    exp_t        q2 [$];
    exp_t        e1, e2;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_dp_be #(.RDW_MODE(0), .OUT_REG(0)) u0 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .byte_en(byte_en),
        .wrt_address(wrt_address), .write(write), .rd_address(rd_address), .read(read),
        .data_out(dout[0]), .rd_valid(vld[0]), .collision(col[0]), .init_busy(busy[0]));
    ram_dp_be #(.RDW_MODE(1), .OUT_REG(0)) u1 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .byte_en(byte_en),
        .wrt_address(wrt_address), .write(write), .rd_address(rd_address), .read(read),
        .data_out(dout[1]), .rd_valid(vld[1]), .collision(col[1]), .init_busy(busy[1]));
    ram_dp_be #(.RDW_MODE(0), .OUT_REG(1)) u2 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .byte_en(byte_en),
        .wrt_address(wrt_address), .write(write), .rd_address(rd_address), .read(read),
        .data_out(dout[2]), .rd_valid(vld[2]), .collision(col[2]), .init_busy(busy[2]));
    ram_dp_be #(.RAM_DEPTH(4000), .RDW_MODE(0), .OUT_REG(0)) u3 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .byte_en(byte_en),
        .wrt_address(wrt_address), .write(write), .rd_address(rd_address), .read(read),
        .data_out(dout[3]), .rd_valid(vld[3]), .collision(col[3]), .init_busy(busy[3]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][63:0] all4(input logic [63:0] x);
        return {x, x, x, x};
    endfunction

    function automatic logic [3:0][63:0] d4(input logic [63:0] a0, input logic [63:0] a1,
                                            input logic [63:0] a2, input logic [63:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Monitor: instances 0,1,3 deliver one cycle after accept, instance 2 two cycles
    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (col[i] && !vld[i]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL collision_without_valid u%0d", i);
                end
            end
            if (vld[0] || vld[1] || vld[3]) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd_valid lat1 at cycle %0d", cyc);
                end else begin
                    e1 = q1.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        if (i != 2) begin
                            chk($sformatf("rd_valid u%0d", i), 64'(vld[i]), 64'd1);
                            chk($sformatf("data_out u%0d", i), dout[i], e1.d[i]);
                            chk($sformatf("collision u%0d", i), 64'(col[i]), 64'(e1.c));
                        end
                    end
                    chk("latency lat1", 64'(cyc), 64'(e1.cyc + 1));
                end
            end
            if (vld[2]) begin
                if (q2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd_valid u2 at cycle %0d", cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk("data_out u2", dout[2], e2.d[2]);
                    chk("collision u2", 64'(col[2]), 64'(e2.c));
                    chk("latency u2", 64'(cyc), 64'(e2.cyc + 2));
                end
            end
        end
    end

    task automatic op(input logic w, input logic [7:0] be, input logic [11:0] wa,
                      input logic [63:0] wd, input logic r, input logic [11:0] ra,
                      input logic [3:0][63:0] ed, input logic ec, input bit push);
        exp_t e;
        write       = w;
        byte_en     = be;
        wrt_address = wa;
        data_in     = wd;
        read        = r;
        rd_address  = ra;
        if (r && push) begin
            e.d   = ed;
            e.c   = ec;
            e.cyc = cyc;
            q1.push_back(e);
            q2.push_back(e);
        end
        @(posedge clock);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        byte_en = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] be, input logic [63:0] d);
        op(1'b1, be, a, d, 1'b0, 12'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [3:0][63:0] ed);
        op(1'b0, 8'h00, 12'd0, 64'd0, 1'b1, a, ed, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s data_out u%0d", tag, i), dout[i], 64'd0);
            chk($sformatf("%s rd_valid u%0d", tag, i), 64'(vld[i]), 64'd0);
            chk($sformatf("%s collision u%0d", tag, i), 64'(col[i]), 64'd0);
            chk($sformatf("%s init_busy u%0d", tag, i), 64'(busy[i]), 64'd1);
        end
    endtask

    // Releases reset and measures the sweep length of every instance
    task automatic sweep();
        int fall [4];
        int k;
        for (int i = 0; i < 4; i++) fall[i] = 0;
        k = 0;
        reset_n    = 1'b1;
        rd_address = '0;
        while ((fall[0] == 0 || fall[1] == 0 || fall[2] == 0 || fall[3] == 0) && k < 5000) begin
            read = (k < 3990);
            @(posedge clock);
            #1;
            k++;
            for (int i = 0; i < 4; i++) begin
                if (fall[i] == 0 && !busy[i]) fall[i] = k;
            end
        end
        read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_cycles u%0d", i), 64'(fall[i]), (i == 3) ? 64'd4000 : 64'd4096);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");
        sweep();

        rd(12'd0,    all4(64'd0));
        rd(12'd2047, all4(64'd0));
        rd(12'd4095, all4(64'd0));

        wr(12'd5, 8'hFF, 64'h1111_2222_3333_4444);
        wr(12'd5, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        rd(12'd5, all4(64'h1111_2222_CCCC_DDDD));
        wr(12'd5, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'd5, all4(64'h1111_2222_CCCC_DDDD));

        wr(12'd9, 8'hFF, 64'h55);
        op(1'b1, 8'hFF, 12'd9, 64'h77, 1'b1, 12'd9, d4(64'h55, 64'h77, 64'h55, 64'h55), 1'b1, 1'b1);
        rd(12'd9, all4(64'h77));
        wr(12'd9, 8'hFF, 64'h55);
        op(1'b1, 8'h01, 12'd9, 64'hFF, 1'b1, 12'd9, d4(64'h55, 64'hFF, 64'h55, 64'h55), 1'b1, 1'b1);
        rd(12'd9, all4(64'hFF));

        wr(12'd1, 8'hFF, 64'hA1);
        wr(12'd2, 8'hFF, 64'hB2);
        wr(12'd3, 8'hFF, 64'hC3);
        rd(12'd1, all4(64'hA1));
        rd(12'd2, all4(64'hB2));
        rd(12'd3, all4(64'hC3));
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold data_out u%0d", i), dout[i], 64'hC3);
            chk($sformatf("hold rd_valid u%0d", i), 64'(vld[i]), 64'd0);
        end

        wr(12'd4000, 8'hFF, 64'hDEAD);
        rd(12'd4000, d4(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'd0));
        op(1'b1, 8'hFF, 12'd4001, 64'hBEEF, 1'b1, 12'd4001, d4(64'd0, 64'hBEEF, 64'd0, 64'd0), 1'b1, 1'b1);
        op(1'b1, 8'hFF, 12'd5, 64'd0, 1'b1, 12'd9, all4(64'hFF), 1'b0, 1'b1);
        drain();

        // Reset with a read still inside the output register of u2
        op(1'b0, 8'h00, 12'd0, 64'd0, 1'b1, 12'd4000, '0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_state("reset_inflight");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clock);
        #1;
        chk("mid_sweep init_busy", 64'(busy[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_state("reset_midsweep");
        @(posedge clock);
        #1;
        sweep();
        rd(12'd5, all4(64'd0));
        rd(12'd9, all4(64'd0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
